// File: rtl/ctr_seq_if.sv
// Command handshake bundle between a host and the ctr_seq command sequencer.
// The host side uses the master modport; the sequencer uses the slave modport.
interface ctr_seq_if #(
  parameter int unsigned BITS     = 3,
  parameter int unsigned LEN_BITS = 4
);
  logic                cmd_valid_in;
  logic                cmd_ready_out;
  logic [1:0]          cmd_op_in;
  logic [BITS-1:0]     cmd_arg_in;
  logic [LEN_BITS-1:0] cmd_len_in;

  modport master (
    output cmd_valid_in,
    output cmd_op_in,
    output cmd_arg_in,
    output cmd_len_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in,
    input  cmd_op_in,
    input  cmd_arg_in,
    input  cmd_len_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/ctr_seq.sv
// Command sequencer for the ctr up/down counter: drives ctr mode/data for each command's length.
// Optional feature macro STOP_AT_MATCH_EN: UP/DOWN runs end early when the counter hits the arg.
module ctr_seq #(
  parameter int unsigned BITS     = 3,
  parameter int unsigned LEN_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ctr_seq_if.slave        cmd_if,
  input  logic            abort_in,
  output logic [1:0]      ctr_mode_out,
  output logic [BITS-1:0] ctr_data_out,
  input  logic [BITS-1:0] ctr_value_in,
  output logic            busy_out,
  output logic            done_out
);

  localparam logic [1:0] OpHold = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpUp   = 2'b10;
  localparam logic [1:0] OpDown = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [1:0]          op_q, op_d;
  logic [BITS-1:0]     arg_q, arg_d;
  logic                match;

`ifdef STOP_AT_MATCH_EN
  assign match = ((op_q == OpUp) || (op_q == OpDown)) && (ctr_value_in == arg_q);
`else
  logic unused_value;
  assign unused_value = ^ctr_value_in;
  assign match        = 1'b0;
`endif

  assign ctr_data_out = arg_q;

  always_comb begin
    state_d              = state_q;
    len_d                = len_q;
    op_d                 = op_q;
    arg_d                = arg_q;
    ctr_mode_out         = OpHold;
    cmd_if.cmd_ready_out = 1'b0;
    busy_out             = 1'b0;
    done_out             = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ready is masked while reset is asserted so nothing is accepted during reset.
        cmd_if.cmd_ready_out = rst_n;
        if (cmd_if.cmd_valid_in) begin
          op_d  = cmd_if.cmd_op_in;
          arg_d = cmd_if.cmd_arg_in;
          len_d = cmd_if.cmd_len_in;
          if (cmd_if.cmd_op_in == OpLoad) begin
            state_d = StLoad;
          end else if (cmd_if.cmd_len_in == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end

      StLoad: begin
        busy_out     = 1'b1;
        ctr_mode_out = abort_in ? OpHold : OpLoad;
        state_d      = StDone;
      end

      StRun: begin
        busy_out = 1'b1;
        len_d    = len_q - LEN_BITS'(1);
        if (abort_in || match) begin
          ctr_mode_out = OpHold;
          state_d      = StDone;
        end else begin
          ctr_mode_out = op_q;
          if (len_q <= LEN_BITS'(1)) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done_out = 1'b1;
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      op_q    <= OpHold;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

endmodule
